// File: rtl/lcd1602_pkg.sv
// Shared types and constants for the HD44780/1602A bus scheduler:
// FSM state encoding, init command bytes and the long-execution classifier.
package lcd1602_pkg;

   typedef enum logic [2:0] {
      PWRUP = 3'd0,
      SETUP = 3'd1,
      EN_HI = 3'd2,
      HOLD  = 3'd3,
      EXEC  = 3'd4,
      ARB   = 3'd5
   } lcd_state_e;

   localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
   localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
   localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
   localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;

   localparam logic [1:0] INIT_LAST_IDX = 2'd3;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = LCD_CMD_FUNCSET;
         2'd1:    cmd = LCD_CMD_DISPON;
         2'd2:    cmd = LCD_CMD_ENTRY;
         default: cmd = LCD_CMD_CLEAR;
      endcase
      return cmd;
   endfunction

   // Clear (01) and home (02/03) are the only commands needing the long wait.
   function automatic logic is_long_exec(input logic rs, input logic [7:0] data_byte);
      return (rs == 1'b0) && (data_byte[7:2] == 6'b000000);
   endfunction

endpackage

// File: rtl/lcd1602_bus_scheduler_if.sv
// Requester handshakes and LCD pin bundle of the bus scheduler.
// master = clients/panel side (testbench), slave = the scheduler itself.
interface lcd1602_bus_scheduler_if;

   logic       a_req;
   logic       a_rs;
   logic [7:0] a_data;
   logic       a_ack;
   logic       b_req;
   logic       b_rs;
   logic [7:0] b_data;
   logic       b_ack;
   logic       init_done;
   logic       busy;
   logic       LCD_EN;
   logic       RS;
   logic       RW;
   logic [7:0] DB8;

   modport master (
      output a_req, a_rs, a_data, b_req, b_rs, b_data,
      input  a_ack, b_ack, init_done, busy, LCD_EN, RS, RW, DB8
   );

   modport slave (
      input  a_req, a_rs, a_data, b_req, b_rs, b_data,
      output a_ack, b_ack, init_done, busy, LCD_EN, RS, RW, DB8
   );

endinterface

// File: rtl/lcd1602_rr_arb2.sv
// Two-way round-robin arbiter; req[0]=A, req[1]=B. last_grant_r=1 means B
// was served last, so A wins the next contested round.
module lcd1602_rr_arb2 (
   input  logic       clk_lcd,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] grant
);

   logic       last_grant_r;
   logic [1:0] grant_s;

   // Grant decode: single requester wins outright, contention alternates.
   always_comb begin
      grant_s = 2'b00;
      if (enable) begin
         case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
         endcase
      end else begin
         grant_s = 2'b00;
      end
   end

   // Remember who was served on every grant.
   always_ff @(posedge clk_lcd or posedge rst) begin
      if (rst) begin
         last_grant_r <= 1'b1;
      end else if (grant_s != 2'b00) begin
         last_grant_r <= grant_s[1];
      end else begin
         last_grant_r <= last_grant_r;
      end
   end

   assign grant = grant_s;

endmodule

// File: rtl/lcd1602_bus_scheduler.sv
// HD44780/1602A write-bus owner: power-up init, then round-robin service of
// two requesters with setup / enable / hold / execution timing per write.
module lcd1602_bus_scheduler
   import lcd1602_pkg::*;
#(
   parameter int unsigned T_SETUP     = 2,
   parameter int unsigned T_EN_HIGH   = 12,
   parameter int unsigned T_HOLD      = 2,
   parameter int unsigned T_EXEC      = 2000,
   parameter int unsigned T_EXEC_LONG = 80000,
   parameter int unsigned T_POWERUP   = 750000,
   parameter int unsigned CNT_W       = 20
) (
   input  logic                     clk_lcd,
   input  logic                     rst,
   lcd1602_bus_scheduler_if.slave   bus
);

   lcd_state_e       state_r;
   lcd_state_e       state_s;
   logic [CNT_W-1:0] timer_r;
   logic [CNT_W-1:0] dur_s;
   logic             timer_done_s;
   logic [1:0]       init_idx_r;
   logic             init_done_r;
   logic             rs_r;
   logic [7:0]       db_r;
   logic             en_r;
   logic             busy_r;
   logic             a_ack_r;
   logic             b_ack_r;
   logic [1:0]       grant_s;
   logic             arb_en_s;

   assign arb_en_s = (state_r == ARB) && init_done_r;

   lcd1602_rr_arb2 u_arb (
      .clk_lcd (clk_lcd),
      .rst     (rst),
      .req     ({bus.b_req, bus.a_req}),
      .enable  (arb_en_s),
      .grant   (grant_s)
   );

   // Last-cycle value of the timer for the current state (duration N -> N-1).
   always_comb begin
      dur_s = {CNT_W{1'b0}};
      case (state_r)
         PWRUP: dur_s = CNT_W'(T_POWERUP - 1);
         SETUP: dur_s = CNT_W'(T_SETUP - 1);
         EN_HI: dur_s = CNT_W'(T_EN_HIGH - 1);
         HOLD:  dur_s = CNT_W'(T_HOLD - 1);
         EXEC: begin
            if (is_long_exec(rs_r, db_r)) begin
               dur_s = CNT_W'(T_EXEC_LONG - 1);
            end else begin
               dur_s = CNT_W'(T_EXEC - 1);
            end
         end
         default: dur_s = {CNT_W{1'b0}};
      endcase
   end

   assign timer_done_s = (timer_r == dur_s);

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         PWRUP: state_s = timer_done_s ? SETUP : PWRUP;
         SETUP: state_s = timer_done_s ? EN_HI : SETUP;
         EN_HI: state_s = timer_done_s ? HOLD  : EN_HI;
         HOLD:  state_s = timer_done_s ? EXEC  : HOLD;
         EXEC: begin
            if (!timer_done_s) begin
               state_s = EXEC;
            end else if (!init_done_r && (init_idx_r != INIT_LAST_IDX)) begin
               state_s = SETUP;
            end else begin
               state_s = ARB;
            end
         end
         ARB: begin
            if (grant_s != 2'b00) begin
               state_s = SETUP;
            end else begin
               state_s = ARB;
            end
         end
         default: state_s = PWRUP;
      endcase
   end

   // State register and per-state timer, cleared on every state entry.
   always_ff @(posedge clk_lcd or posedge rst) begin
      if (rst) begin
         state_r <= PWRUP;
         timer_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         if ((state_s != state_r) || timer_done_s) begin
            timer_r <= {CNT_W{1'b0}};
         end else begin
            timer_r <= timer_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Registered outputs; EN/busy follow the state being entered so the pins
   // line up exactly with the state occupancy.
   always_ff @(posedge clk_lcd or posedge rst) begin
      if (rst) begin
         en_r        <= 1'b0;
         busy_r      <= 1'b1;
         rs_r        <= 1'b0;
         db_r        <= 8'h00;
         a_ack_r     <= 1'b0;
         b_ack_r     <= 1'b0;
         init_idx_r  <= 2'd0;
         init_done_r <= 1'b0;
      end else begin
         en_r    <= (state_s == EN_HI);
         busy_r  <= (state_s != ARB);
         a_ack_r <= 1'b0;
         b_ack_r <= 1'b0;
         case (state_r)
            PWRUP: begin
               if (timer_done_s) begin
                  rs_r       <= 1'b0;
                  db_r       <= init_cmd(2'd0);
                  init_idx_r <= 2'd0;
               end
            end
            EXEC: begin
               if (timer_done_s && !init_done_r) begin
                  if (init_idx_r != INIT_LAST_IDX) begin
                     init_idx_r <= init_idx_r + 2'd1;
                     rs_r       <= 1'b0;
                     db_r       <= init_cmd(init_idx_r + 2'd1);
                  end else begin
                     init_done_r <= 1'b1;
                  end
               end
            end
            ARB: begin
               if (grant_s[0]) begin
                  a_ack_r <= 1'b1;
                  rs_r    <= bus.a_rs;
                  db_r    <= bus.a_data;
               end else if (grant_s[1]) begin
                  b_ack_r <= 1'b1;
                  rs_r    <= bus.b_rs;
                  db_r    <= bus.b_data;
               end
            end
            SETUP, EN_HI, HOLD: begin
               rs_r <= rs_r;
               db_r <= db_r;
            end
            default: begin
               en_r        <= 1'b0;
               busy_r      <= 1'b1;
               rs_r        <= 1'b0;
               db_r        <= 8'h00;
               init_idx_r  <= 2'd0;
               init_done_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_ack     = a_ack_r;
   assign bus.b_ack     = b_ack_r;
   assign bus.init_done = init_done_r;
   assign bus.busy      = busy_r;
   assign bus.LCD_EN    = en_r;
   assign bus.RS        = rs_r;
   assign bus.RW        = 1'b0;
   assign bus.DB8       = db_r;

endmodule

// File: doc/lcd1602_bus_scheduler.md
Name: lcd1602_bus_scheduler

Overview:
- Owns the HD44780/1602A write bus: RS, RW, LCD_EN, DB8.
- After power-up it runs the fixed 4-command init sequence. It then serves two independent write requesters through round-robin arbitration.
- Every write is a timed transaction: setup, enable pulse, hold, then an execution wait sized to the command.
- Sits between the text/refresh engines and the LCD pins, so no client drives the bus or times the panel directly.

Parameters:
- T_SETUP, 2, cycles RS/DB8 stable before LCD_EN rises (≥1).
- T_EN_HIGH, 12, cycles LCD_EN held high (≥1).
- T_HOLD, 2, cycles RS/DB8 held after LCD_EN falls (≥1).
- T_EXEC, 2000, execution wait for normal command/data writes (≥1).
- T_EXEC_LONG, 80000, execution wait for clear/home (≥1).
- T_POWERUP, 750000, wait after reset before the first init command (≥1).
- CNT_W, 20, timer width; must hold max(T_*)−1.

Ports:
- clk_lcd  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- a_req  in  1  requester A write request
- a_rs  in  1  A: 0=command, 1=data
- a_data  in  8  A byte
- a_ack  out  1  one-cycle pulse: A's byte latched
- b_req  in  1  requester B write request
- b_rs  in  1  B: 0=command, 1=data
- b_data  in  8  B byte
- b_ack  out  1  one-cycle pulse: B's byte latched
- init_done  out  1  high once the init sequence completes; stays high until reset
- busy  out  1  high in every state except ARB
- LCD_EN  out  1  panel enable; panel latches on falling edge
- RS  out  1  register select
- RW  out  1  constant 0 (write-only)
- DB8  out  8  panel data bus

Behaviour:
- Reset state: LCD_EN=0, RS=0, DB8=8'h00, a_ack=b_ack=0, init_done=0, busy=1. State is PWRUP, timer=0, init index=0, last_grant=B.
- Async reset mid-transaction: LCD_EN drops immediately, the transaction is abandoned, sequencing restarts from PWRUP.
- All outputs are registered.
- PWRUP: count T_POWERUP cycles, then load init command idx 0 and go to SETUP.
- Init commands in order: 8'h38, 8'h0C, 8'h06, 8'h01, all with RS=0.
- Init transactions use the normal SETUP→EN_HI→HOLD→EXEC path.
- EXEC after an init command: if the index is below 3, increment it and load the next command. After idx 3's EXEC, set init_done=1 and go to ARB.
- Requests are ignored (no ack) while init_done=0.
- ARB: if neither req is high, stay in ARB with busy=0. Otherwise grant a requester:
  - Only one requesting: grant it.
  - Both requesting: grant the one not in last_grant, then update last_grant.
- Grant edge, all on the same clock edge:
  - Pulse the granted ack for exactly one cycle.
  - Latch that requester's rs/data into RS/DB8.
  - Enter SETUP.
- Requester contract: hold rs/data stable while req is high; deassert req or present a new byte the cycle after ack. req is resampled only in ARB.
- SETUP: LCD_EN=0 for T_SETUP cycles.
- EN_HI: LCD_EN=1 for T_EN_HIGH cycles.
- HOLD: LCD_EN=0, RS/DB8 unchanged, for T_HOLD cycles.
- EXEC: wait T_EXEC_LONG if the latched RS=0 and DB8[7:2]==0 (clear 8'h01, home 8'h02/8'h03); otherwise wait T_EXEC. Then return to ARB (or the next init step).
- RS/DB8 keep their last value while idle in ARB.
- Timer: a single CNT_W down/up counter, reloaded on every state entry. A duration of N means exactly N cycles in that state.
- Minimum back-to-back write period: 1 (ARB) + T_SETUP + T_EN_HIGH + T_HOLD + exec.
- Illegal state code: return to PWRUP with outputs at reset values.

Decomposition:
- lcd1602_pkg holds:
  - the state enum: PWRUP, SETUP, EN_HI, HOLD, EXEC, ARB;
  - init command constants: LCD_CMD_FUNCSET=8'h38, LCD_CMD_DISPON=8'h0C, LCD_CMD_ENTRY=8'h06, LCD_CMD_CLEAR=8'h01;
  - the is_long_exec(rs, byte) function.
- One sub-module, lcd1602_rr_arb2: 2-way round-robin arbiter with inputs req[1:0], enable and last_grant register; outputs grant one-hot.

Test Plan (T_POWERUP=20, T_SETUP=1, T_EN_HIGH=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=30):
- Reset release, no requests: LCD_EN first rises at cycle 22 with DB8=8'h38, RS=0. Four pulses follow carrying 38/0C/06/01. The gap after 01 is 30 cycles. init_done rises after that gap, and LCD_EN pulses total exactly 4.
- a_req=1, a_rs=1, a_data=8'h41 held during init: no a_ack before init_done. After init, a_ack pulses once, then one LCD_EN pulse with RS=1, DB8=8'h41, EN high exactly 3 cycles.
- a_req and b_req both held high continuously after init: acks alternate A,B,A,B. Consecutive LCD_EN rising edges are 11 cycles apart (1+1+3+1+5).
- b_req writes command 8'h01 then 8'h80: ARB is re-entered 30 EXEC cycles after the 8'h01 HOLD, and 5 cycles after the 8'h80 HOLD.
- Assert rst mid EN_HI of a user write: LCD_EN=0 in the same cycle, init_done=0, DB8=8'h00. The full init sequence replays after release.
- Idle after init with no requests: busy=0, LCD_EN stays 0, RW=0 throughout, DB8 keeps the last byte written.
